wb_unit: RTL

Writeback unit driving the register file's single write port (`write_enable`, `w_addr`, `w_data`). It takes single-cycle ALU results, plus in-order load responses from data memory that were announced at issue time. Load data is byte/halfword extracted and sign/zero extended per RISC-V load type before being written. It also publishes a per-register pending vector so ID can stall on registers with outstanding loads.

---
 rtl/wb_unit.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_unit.sv
// wb_unit: writeback stage owning the register file's single write port.
//
// Merges single-cycle ALU results with in-order load responses. Loads are
// announced at issue time into a small FIFO ({rd, funct3, offset}); when the
// memory word for the oldest load arrives it is byte/halfword extracted,
// sign/zero extended, and parked in a one-entry hold register (L) until the
// write port is free. ALU writes always win the port; L waits behind them.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   alu_valid/alu_rd/alu_data       ALU result (never stalled)
//   ld_issue/ld_rd/ld_funct3/
//   ld_offset, ld_ready             load announcement and queue-space flag
//   mem_resp_valid/mem_resp_data,
//   mem_resp_ready                  memory response handshake (oldest load)
//   write_enable/w_addr/w_data      registered register-file write port
//   pending                         registers with an unfinished load write
module wb_unit #(
    parameter int LQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_issue,
    input  logic [4:0]  ld_rd,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    output logic        ld_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        mem_resp_ready,
    output logic        write_enable,
    output logic [4:0]  w_addr,
    output logic [31:0] w_data,
    output logic [31:0] pending
);
    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] offset;
    } lq_entry_t;

    lq_entry_t        lq_mem_q [LQ_DEPTH];
    lq_entry_t        lq_mem_d [LQ_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             l_valid_q, l_valid_d;
    logic [4:0]       l_rd_q, l_rd_d;
    logic [31:0]      l_data_q, l_data_d;

    logic             we_q, we_d;
    logic [4:0]       w_addr_q, w_addr_d;
    logic [31:0]      w_data_q, w_data_d;
    logic             out_load_q, out_load_d;

    logic             alu_wr;
    logic             l_drain;
    logic             push;
    logic             pop;
    lq_entry_t        head;
    logic [31:0]      fmt_data;
    logic [31:0]      pending_vec;

    // ALU writes to x0 are dropped outright so they never hold L back.
    assign alu_wr  = alu_valid && (alu_rd != 5'd0);
    // L empties this cycle if it either wins the port or targets x0.
    assign l_drain = l_valid_q && ((l_rd_q == 5'd0) || !alu_wr);

    // Space is judged from the current count only; a same-cycle pop does not
    // open a slot for a push.
    assign ld_ready       = count_q < CNT_W'(LQ_DEPTH);
    assign mem_resp_ready = (count_q != '0) && (!l_valid_q || l_drain);
    assign push           = ld_issue && ld_ready;
    assign pop            = mem_resp_valid && mem_resp_ready;
    assign head           = lq_mem_q[rd_ptr_q];

    // Load data formatting for the head entry.
    always_comb begin
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        // NOTE: every variable assigned in always_comb gets a value on every
        // path (default first or a full case), otherwise a latch is inferred.
        case (head.offset)
            2'd0:    byte_sel = mem_resp_data[7:0];
            2'd1:    byte_sel = mem_resp_data[15:8];
            2'd2:    byte_sel = mem_resp_data[23:16];
            default: byte_sel = mem_resp_data[31:24];
        endcase
        half_sel = head.offset[1] ? mem_resp_data[31:16] : mem_resp_data[15:0];
        case (head.funct3)
            3'b000:  fmt_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  fmt_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  fmt_data = {24'd0, byte_sel};
            3'b101:  fmt_data = {16'd0, half_sel};
            default: fmt_data = mem_resp_data;
        endcase
    end

    // Load queue next state.
    always_comb begin
        lq_mem_d = lq_mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            lq_mem_d[wr_ptr_q] = '{rd: ld_rd, funct3: ld_funct3, offset: ld_offset};
            wr_ptr_d           = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Hold register and write-port arbitration.
    always_comb begin
        l_valid_d  = l_valid_q;
        l_rd_d     = l_rd_q;
        l_data_d   = l_data_q;
        we_d       = 1'b0;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;
        out_load_d = 1'b0;

        if (alu_wr) begin
            we_d     = 1'b1;
            w_addr_d = alu_rd;
            w_data_d = alu_data;
        end else if (l_valid_q && (l_rd_q != 5'd0)) begin
            we_d       = 1'b1;
            w_addr_d   = l_rd_q;
            w_data_d   = l_data_q;
            out_load_d = 1'b1;
        end

        // A pop is only possible when L is empty or draining, so refilling
        // here never overwrites an unwritten load.
        if (pop) begin
            l_valid_d = 1'b1;
            l_rd_d    = head.rd;
            l_data_d  = fmt_data;
        end else if (l_drain) begin
            l_valid_d = 1'b0;
        end
    end

    // Outstanding-load scoreboard: queue entries, L, and a load on the port.
    always_comb begin
        logic [PTR_W-1:0] idx;
        pending_vec = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                pending_vec[lq_mem_q[idx].rd] = 1'b1;
            end
        end
        if (l_valid_q) begin
            pending_vec[l_rd_q] = 1'b1;
        end
        if (out_load_q) begin
            pending_vec[w_addr_q] = 1'b1;
        end
        pending_vec[0] = 1'b0;
    end

    // NOTE: queue storage is not reset; validity comes from the pointers and
    // count, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        lq_mem_q <= lq_mem_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            l_valid_q  <= 1'b0;
            l_rd_q     <= 5'd0;
            l_data_q   <= 32'd0;
            we_q       <= 1'b0;
            w_addr_q   <= 5'd0;
            w_data_q   <= 32'd0;
            out_load_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            l_valid_q  <= l_valid_d;
            l_rd_q     <= l_rd_d;
            l_data_q   <= l_data_d;
            we_q       <= we_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
            out_load_q <= out_load_d;
        end
    end

    assign write_enable = we_q;
    assign w_addr       = w_addr_q;
    assign w_data       = w_data_q;
    assign pending      = pending_vec;

endmodule
